// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  localparam logic [2:0] MEMSIZE_W = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// sat_o flags that the count has reached MAX; latency 1 cycle from inc/clr.
module arb_sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == MAX_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-fetch and load/store ports onto one single-port memory, one transaction at a time.
// Grant in cycle N, mem_* from N+1, ack combinational on mem_ready; requesters stall until ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255,
  parameter int CNTW        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic        iack,
  output logic [31:0] irdata,
  output logic        istall,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [2:0]  dsize,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic        dack,
  output logic [31:0] drdata,
  output logic        dstall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);

  arb_state_t  state_q;
  logic        mem_req_q, mem_we_q, bus_err_q;
  logic [2:0]  mem_size_q;
  logic [31:0] mem_addr_q, mem_wdata_q;

  logic idle, busy, grant_d, grant_i, streak_sat, wd_sat;
  logic done_ok, expire, finish;

  assign idle    = (state_q == IDLE);
  assign busy    = !idle;
  // Once D has won MAX_DSTREAK times in a row over a waiting fetch, the fetch goes first.
  assign grant_d = idle && dreq && !(ireq && streak_sat);
  assign grant_i = idle && ireq && !grant_d;

  // A real completion in the expiry cycle takes precedence over the watchdog abort.
  assign done_ok = busy && mem_ready;
  assign expire  = busy && !mem_ready && wd_sat;
  assign finish  = done_ok || expire;

  assign iack   = finish && (state_q == IBUSY);
  assign dack   = finish && (state_q == DBUSY);
  assign irdata = (done_ok && state_q == IBUSY) ? mem_rdata : '0;
  assign drdata = (done_ok && state_q == DBUSY) ? mem_rdata : '0;
  assign istall = ireq && !iack && !reset;
  assign dstall = dreq && !dack && !reset;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;

  arb_sat_counter #(.W(SW), .MAX(MAX_DSTREAK)) u_streak (
    .clk   (clk),
    .rst   (reset),
    .inc_i (grant_d && ireq),
    .clr_i (grant_i || (grant_d && !ireq)),
    .sat_o (streak_sat)
  );

  arb_sat_counter #(.W(CNTW), .MAX(TIMEOUT)) u_watchdog (
    .clk   (clk),
    .rst   (reset),
    .inc_i (busy && !mem_ready),
    .clr_i (grant_d || grant_i),
    .sat_o (wd_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= DBUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dwe;
            mem_size_q  <= dsize;
            mem_addr_q  <= daddr;
            mem_wdata_q <= dwdata;
          end else if (grant_i) begin
            state_q     <= IBUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_size_q  <= MEMSIZE_W;
            mem_addr_q  <= iaddr;
            mem_wdata_q <= '0;
          end
        end
        default: begin
          if (finish) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
          if (expire) begin
            bus_err_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
